// File: rtl/execute_if.sv
// ----------------------------------------------------------------------------
// execute_if -- bundle of all signals exchanged by the EX pipeline stage.
//
// Purpose : groups the ID/EX control and operand inputs, the writeback
//           forwarding bus, the registered EX/MEM outputs and the
//           combinational jump redirect into one interface.
// Modports:
//   master -- upstream side (decode/writeback driver): drives ID/EX
//             inputs and the writeback bus, observes EX/MEM and redirect.
//   slave  -- the execute stage itself.
// Signals :
//   flushE                             turn the EX instruction into a bubble
//   regwriteE, memrwE, aselE, bselE    ID/EX control bits
//   wbselE[1:0]                        writeback select (00 mem, 01 alu, 11 pc+4)
//   aluselE[2:0]                       ALU operation
//   rdE, rs1E, rs2E[4:0]               register indices
//   rd1E, rd2E, imm_exE, pcE, pc4E     operands, immediate, PC, PC+4
//   regwriteW, rdW, resultW            writeback bus used for forwarding
//   regwriteM, memrwM, wbselM, rdM     EX/MEM control (registered)
//   aluresultM, writedataM, pc4M       EX/MEM data (registered)
//   pcselE, pctargetE                  jump redirect to fetch (combinational)
// ----------------------------------------------------------------------------
interface execute_if #(
  parameter int XLEN = 32
);
  logic            flushE;
  logic            regwriteE;
  logic            memrwE;
  logic            aselE;
  logic            bselE;
  logic [1:0]      wbselE;
  logic [2:0]      aluselE;
  logic [4:0]      rdE;
  logic [4:0]      rs1E;
  logic [4:0]      rs2E;
  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] imm_exE;
  logic [XLEN-1:0] pcE;
  logic [XLEN-1:0] pc4E;
  logic            regwriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] resultW;
  logic            regwriteM;
  logic            memrwM;
  logic [1:0]      wbselM;
  logic [4:0]      rdM;
  logic [XLEN-1:0] aluresultM;
  logic [XLEN-1:0] writedataM;
  logic [XLEN-1:0] pc4M;
  logic            pcselE;
  logic [XLEN-1:0] pctargetE;

  modport master (
    output flushE, regwriteE, memrwE, aselE, bselE, wbselE, aluselE,
           rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E,
           regwriteW, rdW, resultW,
    input  regwriteM, memrwM, wbselM, rdM, aluresultM, writedataM, pc4M,
           pcselE, pctargetE
  );

  modport slave (
    input  flushE, regwriteE, memrwE, aselE, bselE, wbselE, aluselE,
           rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E,
           regwriteW, rdW, resultW,
    output regwriteM, memrwM, wbselM, rdM, aluresultM, writedataM, pc4M,
           pcselE, pctargetE
  );
endinterface

// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute -- EX pipeline stage with operand forwarding, ALU, jump redirect
//            and the EX/MEM pipeline register.
//
// Ports:
//   clk  -- single clock, all state updates on its rising edge
//   rst  -- synchronous, active-high reset
//   bus  -- execute_if.slave; see execute_if.sv for the signal list
//
// Forwarding priority: M stage beats W stage beats the register-file read.
// A write to x0 is never forwarded. The M-stage value forwarded is always
// the ALU result; load-use hazards are resolved by stalls upstream.
// ----------------------------------------------------------------------------
module execute #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  execute_if.slave  bus
);

  // EX/MEM pipeline register state
  logic            regwrite_q, regwrite_d;
  logic            memrw_q,    memrw_d;
  logic [1:0]      wbsel_q,    wbsel_d;
  logic [4:0]      rd_q,       rd_d;
  logic [XLEN-1:0] aluresult_q, aluresult_d;
  logic [XLEN-1:0] writedata_q, writedata_d;
  logic [XLEN-1:0] pc4_q,       pc4_d;

  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;
  logic [XLEN-1:0] op_a_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] alu_res_s;
  logic            m_hit_a_s, m_hit_b_s, w_hit_a_s, w_hit_b_s;

  // Hazard detection: a producer only counts when it writes a non-x0 register
  always_comb begin
    m_hit_a_s = regwrite_q    && (rd_q   != 5'd0) && (rd_q   == bus.rs1E);
    m_hit_b_s = regwrite_q    && (rd_q   != 5'd0) && (rd_q   == bus.rs2E);
    w_hit_a_s = bus.regwriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs1E);
    w_hit_b_s = bus.regwriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs2E);
  end

  // Forwarding muxes: M match is checked first so it wins over W
  always_comb begin
    if (m_hit_a_s) begin
      fwd_a_s = aluresult_q;
    end else if (w_hit_a_s) begin
      fwd_a_s = bus.resultW;
    end else begin
      fwd_a_s = bus.rd1E;
    end
    if (m_hit_b_s) begin
      fwd_b_s = aluresult_q;
    end else if (w_hit_b_s) begin
      fwd_b_s = bus.resultW;
    end else begin
      fwd_b_s = bus.rd2E;
    end
  end

  // Operand selection and ALU (wraps modulo 2^XLEN, no flags)
  always_comb begin
    op_a_s = bus.aselE ? bus.pcE     : fwd_a_s;
    op_b_s = bus.bselE ? bus.imm_exE : fwd_b_s;
    case (bus.aluselE)
      3'b000:  alu_res_s = op_a_s + op_b_s;
      3'b001:  alu_res_s = op_a_s - op_b_s;
      3'b010:  alu_res_s = op_a_s & op_b_s;
      3'b011:  alu_res_s = op_a_s | op_b_s;
      3'b100:  alu_res_s = op_a_s ^ op_b_s;
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state of the EX/MEM register: a flushed instruction becomes all-zero
  always_comb begin
    if (bus.flushE) begin
      regwrite_d  = 1'b0;
      memrw_d     = 1'b0;
      wbsel_d     = 2'b00;
      rd_d        = 5'd0;
      aluresult_d = {XLEN{1'b0}};
      writedata_d = {XLEN{1'b0}};
      pc4_d       = {XLEN{1'b0}};
    end else begin
      regwrite_d  = bus.regwriteE;
      memrw_d     = bus.memrwE;
      wbsel_d     = bus.wbselE;
      rd_d        = bus.rdE;
      aluresult_d = alu_res_s;
      writedata_d = fwd_b_s;
      pc4_d       = bus.pc4E;
    end
  end

  // EX/MEM register, synchronous reset clears every field
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      memrw_q     <= 1'b0;
      wbsel_q     <= 2'b00;
      rd_q        <= 5'd0;
      aluresult_q <= {XLEN{1'b0}};
      writedata_q <= {XLEN{1'b0}};
      pc4_q       <= {XLEN{1'b0}};
    end else begin
      regwrite_q  <= regwrite_d;
      memrw_q     <= memrw_d;
      wbsel_q     <= wbsel_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      pc4_q       <= pc4_d;
    end
  end

  // Jump redirect: only a live (not flushed, not in reset) pc+4 writeback jumps
  assign bus.pcselE    = (bus.wbselE == 2'b11) && !bus.flushE && !rst;
  assign bus.pctargetE = {alu_res_s[XLEN-1:1], 1'b0};

  assign bus.regwriteM  = regwrite_q;
  assign bus.memrwM     = memrw_q;
  assign bus.wbselM     = wbsel_q;
  assign bus.rdM        = rd_q;
  assign bus.aluresultM = aluresult_q;
  assign bus.writedataM = writedata_q;
  assign bus.pc4M       = pc4_q;

endmodule

// File: tb/tb_execute.sv
// ----------------------------------------------------------------------------
// tb_execute -- self-checking bench for the execute stage.
// Directed scenarios followed by randomized instruction streams, all checked
// against a behavioural model that tracks what the EX/MEM register should hold.
// ----------------------------------------------------------------------------
module tb_execute;
  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  execute_if #(.XLEN(XLEN)) bus ();

  execute #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction currently sitting in the MEM stage
  logic            m_rw, m_mrw;
  logic [1:0]      m_wbsel;
  logic [4:0]      m_rd;
  logic [31:0]     m_alu, m_wdata, m_pc4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Latest value of register rs as seen by the EX stage
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf_val);
    if (rs == 5'd0) return rf_val;
    if (m_rw && m_rd == rs) return m_alu;
    if (bus.regwriteW && bus.rdW == rs) return bus.resultW;
    return rf_val;
  endfunction

  task automatic set_instr(input logic rw, input logic mrw, input logic asel, input logic bsel,
                           input logic [1:0] wbsel, input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc);
    bus.regwriteE = rw;   bus.memrwE = mrw;  bus.aselE = asel; bus.bselE = bsel;
    bus.wbselE = wbsel;   bus.aluselE = op;  bus.rdE = rd;
    bus.rs1E = rs1;       bus.rs2E = rs2;    bus.rd1E = rd1;   bus.rd2E = rd2;
    bus.imm_exE = imm;    bus.pcE = pc;      bus.pc4E = pc + 32'd4;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] rd, input logic [31:0] res);
    bus.regwriteW = rw; bus.rdW = rd; bus.resultW = res;
  endtask

  // One cycle: check redirect before the edge, check EX/MEM after it
  task automatic run_cycle(input logic rst_v);
    logic [31:0] a, b, res, fb;
    logic        exp_pcsel, kill;
    rst = rst_v;
    #1;
    fb  = operand(bus.rs2E, bus.rd2E);
    a   = bus.aselE ? bus.pcE : operand(bus.rs1E, bus.rd1E);
    b   = bus.bselE ? bus.imm_exE : fb;
    res = alu_ref(bus.aluselE, a, b);
    exp_pcsel = (bus.wbselE == 2'b11) && !bus.flushE && !rst_v;
    check("pcselE", {31'd0, bus.pcselE}, {31'd0, exp_pcsel});
    if (exp_pcsel) check("pctargetE", bus.pctargetE, res & ~32'd1);
    kill = rst_v || bus.flushE;
    @(posedge clk);
    m_rw    = kill ? 1'b0  : bus.regwriteE;
    m_mrw   = kill ? 1'b0  : bus.memrwE;
    m_wbsel = kill ? 2'd0  : bus.wbselE;
    m_rd    = kill ? 5'd0  : bus.rdE;
    m_alu   = kill ? 32'd0 : res;
    m_wdata = kill ? 32'd0 : fb;
    m_pc4   = kill ? 32'd0 : bus.pc4E;
    #1;
    check("regwriteM",  {31'd0, bus.regwriteM}, {31'd0, m_rw});
    check("memrwM",     {31'd0, bus.memrwM},    {31'd0, m_mrw});
    check("wbselM",     {30'd0, bus.wbselM},    {30'd0, m_wbsel});
    check("rdM",        {27'd0, bus.rdM},       {27'd0, m_rd});
    check("aluresultM", bus.aluresultM, m_alu);
    check("writedataM", bus.writedataM, m_wdata);
    check("pc4M",       bus.pc4M,       m_pc4);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_rw = 1'b0; m_mrw = 1'b0; m_wbsel = 2'd0; m_rd = 5'd0;
    m_alu = 32'd0; m_wdata = 32'd0; m_pc4 = 32'd0;
    rst = 1'b1;
    bus.flushE = 1'b0;
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 3'd0, 5'd7, 5'd1, 5'd2,
              32'h11, 32'h22, 32'h33, 32'h100);
    set_wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);

    // Reset state
    run_cycle(1'b1);
    check("rst_alu", bus.aluresultM, 32'd0);
    check("rst_rw", {31'd0, bus.regwriteM}, 32'd0);

    // add 5+7
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd4, 5'd1, 5'd2,
              32'd5, 32'd7, 32'd0, 32'h200);
    run_cycle(1'b0);
    check("add_res", bus.aluresultM, 32'd12);
    check("add_rd",  {27'd0, bus.rdM}, 32'd4);

    // sub wrap 0-1 (sources not matching rdM=4)
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 5'd5, 5'd1, 5'd2,
              32'd0, 32'd1, 32'd0, 32'h204);
    run_cycle(1'b0);
    check("sub_wrap", bus.aluresultM, 32'hFFFF_FFFF);

    // addi x1 = x0 + 10, then add x2 = x1 + x1 with stale rf values
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'd0, 5'd1, 5'd0, 5'd0,
              32'd0, 32'd0, 32'd10, 32'h208);
    run_cycle(1'b0);
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd2, 5'd1, 5'd1,
              32'd99, 32'd99, 32'd0, 32'h20C);
    run_cycle(1'b0);
    check("fwd_m", bus.aluresultM, 32'd20);

    // M writes x3=9, W writes x3=4 at the same time: M wins
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'd0, 5'd3, 5'd0, 5'd0,
              32'd0, 32'd0, 32'd9, 32'h210);
    run_cycle(1'b0);
    set_wb(1'b1, 5'd3, 32'd4);
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd6, 5'd3, 5'd0,
              32'd55, 32'd0, 32'd0, 32'h214);
    run_cycle(1'b0);
    check("fwd_m_over_w", bus.aluresultM, 32'd9);

    // Same with rd = x0: nothing forwarded, rd1E used
    set_wb(1'b0, 5'd0, 32'd0);
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'd0, 5'd0, 5'd0, 5'd0,
              32'd0, 32'd0, 32'd9, 32'h218);
    run_cycle(1'b0);
    set_wb(1'b1, 5'd0, 32'd4);
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd6, 5'd0, 5'd0,
              32'd0, 32'd0, 32'd0, 32'h21C);
    run_cycle(1'b0);
    check("x0_nofwd", bus.aluresultM, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);

    // jalr: rs1 = 0x101 via rf, imm 4
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'd0, 5'd1, 5'd9, 5'd0,
              32'h101, 32'd0, 32'd4, 32'h300);
    #1;
    check("jalr_pcsel",  {31'd0, bus.pcselE}, 32'd1);
    check("jalr_target", bus.pctargetE, 32'h104);
    run_cycle(1'b0);
    check("jalr_pc4", bus.pc4M, 32'h304);

    // Flushed sw
    bus.flushE = 1'b1;
    set_instr(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 3'd0, 5'd0, 5'd1, 5'd2,
              32'h40, 32'h41, 32'h8, 32'h400);
    #1;
    check("flush_pcsel", {31'd0, bus.pcselE}, 32'd0);
    run_cycle(1'b0);
    check("flush_memrw", {31'd0, bus.memrwM}, 32'd0);
    bus.flushE = 1'b0;

    // Reset pulse mid-stream, then a consumer of the discarded rd
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd8, 5'd1, 5'd2,
              32'd3, 32'd4, 32'd0, 32'h500);
    run_cycle(1'b0);
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd0, 5'd8, 5'd1, 5'd2,
              32'd3, 32'd4, 32'd0, 32'h504);
    run_cycle(1'b1);
    check("rstmid_pc4", bus.pc4M, 32'd0);
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 5'd9, 5'd8, 5'd0,
              32'd1, 32'd0, 32'd0, 32'h508);
    run_cycle(1'b0);
    check("post_rst_nofwd", bus.aluresultM, 32'd1);

    // Randomized streams with small register indices to provoke hazards
    for (int i = 0; i < 300; i++) begin
      bus.flushE = ($urandom_range(7) == 0);
      set_instr($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                2'($urandom_range(3)), 3'($urandom_range(7)), 5'($urandom_range(3)),
                5'($urandom_range(3)), 5'($urandom_range(3)), $urandom, $urandom,
                $urandom, $urandom);
      set_wb($urandom_range(1), 5'($urandom_range(3)), $urandom);
      run_cycle($urandom_range(19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
